// File: rtl/ddr_arb_pkg.sv
// Shared types and defaults for the DDR control-port arbiter.
package ddr_arb_pkg;

  localparam int unsigned DDR_ADDR_W  = 25;
  localparam int unsigned DDR_DATA_W  = 256;
  localparam int unsigned DDR_BE_W    = DDR_DATA_W / 8;
  localparam int unsigned DDR_TIMEOUT = 1023;

  // Client slots on the arbiter's request vectors
  localparam int unsigned CLI_SETUP = 0;
  localparam int unsigned CLI_PKT   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to the client that was not served last.
module rr_arb2
  import ddr_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [0:0] last_i,
  output logic [1:0] gnt_c
);

  // One-hot pick from the current request pair and last-served index
  always_comb begin
    gnt_c = '0;
    case (req_i)
      2'b01:   gnt_c[CLI_SETUP] = 1'b1;
      2'b10:   gnt_c[CLI_PKT]   = 1'b1;
      2'b11: begin
        if (last_i[0]) gnt_c[CLI_SETUP] = 1'b1;
        else           gnt_c[CLI_PKT]   = 1'b1;
      end
      default: gnt_c = '0;
    endcase
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares the avalon_mm_ddr control port between the setup/write client (0)
// and the packet/read client (1). One transaction in flight, round-robin,
// grants only while DDR calibration is good.
// Optional watchdog on action_done: define DDR_ARB_TIMEOUT_EN.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DDR_ADDR_W,
  parameter int unsigned DATA_W  = DDR_DATA_W,
  parameter int unsigned BE_W    = DDR_BE_W,
  parameter int unsigned TIMEOUT = DDR_TIMEOUT
) (
  input  logic                avalon_clk,
  input  logic                avalon_reset,
  input  logic                cal_ok,
  input  logic [1:0]          c_req,
  input  logic [1:0]          c_we,
  input  logic [2*ADDR_W-1:0] c_addr,
  input  logic [2*DATA_W-1:0] c_wdata,
  input  logic [2*BE_W-1:0]   c_be,
  output logic [1:0]          c_ack,
  output logic [1:0]          c_err,
  output logic [1:0]          c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  output logic [1:0]          grant,
  output logic                wr_rq,
  output logic                rd_rq,
  output logic [ADDR_W-1:0]   wr_adr,
  output logic [ADDR_W-1:0]   rd_adr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [BE_W-1:0]     byte_enable,
  input  logic                rd_valid,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                action_done,
  output logic                timeout_flag
);

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
`endif

  arb_state_e          state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [0:0]          last_q, last_d;
  logic                wr_rq_q, wr_rq_d;
  logic                rd_rq_q, rd_rq_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                we_q, we_d;
`ifdef DDR_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          err_q, err_d;
  logic                tflag_q, tflag_d;
`else
  // TIMEOUT only matters when the watchdog is built in
  logic                unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  logic [1:0]          pick_c;
  logic                pick_idx_c;

  rr_arb2 u_rr_arb2 (
    .req_i  (c_req),
    .last_i (last_q),
    .gnt_c  (pick_c)
  );

  assign pick_idx_c = pick_c[CLI_PKT];

  // Next-state and registered-output logic for IDLE -> ISSUE -> WAIT
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wr_rq_d  = 1'b0;
    rd_rq_d  = 1'b0;
    ack_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
`ifdef DDR_ARB_TIMEOUT_EN
    cnt_d    = '0;
    err_d    = '0;
    tflag_d  = tflag_q;
`endif

    case (state_q)
      IDLE: begin
        if (cal_ok && (c_req != 2'b00)) begin
          grant_d = pick_c;
          if (pick_idx_c) begin
            addr_d  = c_addr[CLI_PKT*ADDR_W +: ADDR_W];
            wdata_d = c_wdata[CLI_PKT*DATA_W +: DATA_W];
            be_d    = c_be[CLI_PKT*BE_W +: BE_W];
            we_d    = c_we[CLI_PKT];
          end else begin
            addr_d  = c_addr[CLI_SETUP*ADDR_W +: ADDR_W];
            wdata_d = c_wdata[CLI_SETUP*DATA_W +: DATA_W];
            be_d    = c_be[CLI_SETUP*BE_W +: BE_W];
            we_d    = c_we[CLI_SETUP];
          end
          // Request pulse lands in the same cycle the grant becomes visible
          wr_rq_d = we_d;
          rd_rq_d = ~we_d;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (rd_valid && !we_q) begin
          rdata_d  = rd_data;
          rvalid_d = grant_q;
        end
        if (action_done) begin
          ack_d   = grant_q;
          last_d  = grant_q[CLI_PKT:CLI_PKT];
          grant_d = '0;
          state_d = IDLE;
        end
`ifdef DDR_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = grant_q;
          tflag_d = 1'b1;
          last_d  = grant_q[CLI_PKT:CLI_PKT];
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction
  always_ff @(posedge avalon_clk or posedge avalon_reset) begin
    if (avalon_reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= 1'b1;  // client 1 counted as last served: client 0 wins the first tie
      wr_rq_q  <= 1'b0;
      rd_rq_q  <= 1'b0;
      ack_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= '0;
      tflag_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wr_rq_q  <= wr_rq_d;
      rd_rq_q  <= rd_rq_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
`ifdef DDR_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      tflag_q  <= tflag_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign wr_rq       = wr_rq_q;
  assign rd_rq       = rd_rq_q;
  assign wr_adr      = addr_q;
  assign rd_adr      = addr_q;
  assign wr_data     = wdata_q;
  assign byte_enable = be_q;
  assign c_ack       = ack_q;
  assign c_rvalid    = rvalid_q;
  assign c_rdata     = rdata_q;
`ifdef DDR_ARB_TIMEOUT_EN
  assign c_err        = err_q;
  assign timeout_flag = tflag_q;
`else
  assign c_err        = '0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (who wins, what was latched, when the
// ack/rvalid/err pulses appear).
`timescale 1ns/1ps
module tb_ddr_port_arbiter;

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 256;
  localparam int unsigned BW = 32;
  localparam int unsigned TO = 20;

  logic            avalon_clk = 1'b0;
  logic            avalon_reset;
  logic            cal_ok;
  logic [1:0]      c_req, c_we;
  logic [2*AW-1:0] c_addr;
  logic [2*DW-1:0] c_wdata;
  logic [2*BW-1:0] c_be;
  logic [1:0]      c_ack, c_err, c_rvalid, grant;
  logic [DW-1:0]   c_rdata, wr_data, rd_data;
  logic            wr_rq, rd_rq, rd_valid, action_done, timeout_flag;
  logic [AW-1:0]   wr_adr, rd_adr;
  logic [BW-1:0]   byte_enable;

  always #5 avalon_clk = ~avalon_clk;

  ddr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .TIMEOUT(TO)) dut (
    .avalon_clk   (avalon_clk),
    .avalon_reset (avalon_reset),
    .cal_ok       (cal_ok),
    .c_req        (c_req),
    .c_we         (c_we),
    .c_addr       (c_addr),
    .c_wdata      (c_wdata),
    .c_be         (c_be),
    .c_ack        (c_ack),
    .c_err        (c_err),
    .c_rvalid     (c_rvalid),
    .c_rdata      (c_rdata),
    .grant        (grant),
    .wr_rq        (wr_rq),
    .rd_rq        (rd_rq),
    .wr_adr       (wr_adr),
    .rd_adr       (rd_adr),
    .wr_data      (wr_data),
    .byte_enable  (byte_enable),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .action_done  (action_done),
    .timeout_flag (timeout_flag)
  );

  int checks = 0;
  int errors = 0;

  // Model state: last-served client and each client's currently driven payload
  int            last_srv;
  logic          m_we   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  logic [BW-1:0] m_be   [2];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge avalon_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic load(input int i, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] be);
    m_we[i] = we; m_addr[i] = a; m_data[i] = d; m_be[i] = be;
    c_we[i] = we;
    c_addr[i*AW +: AW]  = a;
    c_wdata[i*DW +: DW] = d;
    c_be[i*BW +: BW]    = be;
  endtask

  task automatic load_rand(input int i);
    load(i, 1'($urandom_range(0, 1)), AW'($urandom), rnd(), BW'($urandom));
  endtask

  // Lone requester wins; a tie goes to whoever was not served last
  function automatic int model_pick(input logic [1:0] req);
    if (req == 2'b11) return 1 - last_srv;
    return req[1] ? 1 : 0;
  endfunction

  task automatic chk_payload(input string tag, input int o);
    if (m_we[o]) begin
      chk({tag, "_wr_adr"}, wr_adr, m_addr[o]);
      chk({tag, "_wr_data"}, wr_data, m_data[o]);
    end else begin
      chk({tag, "_rd_adr"}, rd_adr, m_addr[o]);
    end
    chk({tag, "_be"}, byte_enable, m_be[o]);
  endtask

  // Runs one transaction starting from the IDLE cycle in which c_req is already driven.
  // rv_dly: WAIT cycle index carrying rd_valid (-1 = none); done_dly: index carrying action_done.
  task automatic serve(input int done_dly, input int rv_dly, input logic [DW-1:0] rv_val,
                       input bit drop_cal, output int owner);
    logic [1:0] oh;
    logic       we;
    owner = model_pick(c_req);
    oh    = (owner == 1) ? 2'b10 : 2'b01;
    we    = m_we[owner];
    tick();  // ISSUE
    chk("issue_grant", grant, oh);
    chk("issue_wr_rq", wr_rq, we);
    chk("issue_rd_rq", rd_rq, !we);
    chk_payload("issue", owner);
    load_rand(1 - owner);  // non-owner inputs wander freely
    if (drop_cal) cal_ok = 1'b0;
    tick();  // first WAIT cycle
    chk("wait_wr_rq", wr_rq, 1'b0);
    chk("wait_rd_rq", rd_rq, 1'b0);
    for (int k = 0; k <= done_dly; k++) begin
      rd_valid    = (k == rv_dly);
      rd_data     = (k == rv_dly) ? rv_val : rnd();
      action_done = (k == done_dly);
      if (k == done_dly) cal_ok = 1'b1;
      tick();
      rd_valid    = 1'b0;
      action_done = 1'b0;
      chk("rvalid", c_rvalid, (k == rv_dly && !we) ? oh : 2'b00);
      if (k == rv_dly && !we) chk("rdata", c_rdata, rv_val);
      chk("ack", c_ack, (k == done_dly) ? oh : 2'b00);
      chk("err", c_err, 2'b00);
      chk("grant_hold", grant, (k == done_dly) ? 2'b00 : oh);
      if (k < done_dly) chk_payload("hold", owner);
    end
    last_srv = owner;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int own, dd, rv;
    logic [1:0] oh;

    avalon_reset = 1'b1; cal_ok = 1'b0; c_req = '0; c_we = '0;
    c_addr = '0; c_wdata = '0; c_be = '0;
    rd_valid = 1'b0; rd_data = '0; action_done = 1'b0;
    last_srv = 1;
    for (int i = 0; i < 2; i++) load(i, 1'b0, '0, '0, '0);
    #23;
    chk("rst_grant", grant, 2'b00);
    chk("rst_wr_rq", wr_rq, 1'b0);
    chk("rst_rd_rq", rd_rq, 1'b0);
    chk("rst_ack", c_ack, 2'b00);
    chk("rst_tflag", timeout_flag, 1'b0);
    @(negedge avalon_clk) avalon_reset = 1'b0;
    tick();

    // Calibration gate: a pending request must not be granted while cal_ok is low
    load(0, 1'b1, 25'h10, {32{8'hA5}}, '1);
    c_req = 2'b01;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("nocal_grant", grant, 2'b00);
      chk("nocal_rq", {wr_rq, rd_rq}, 2'b00);
    end
    cal_ok = 1'b1;
    serve(5, -1, '0, 1'b0, own);
    chk("first_owner", own, 0);
    c_req = 2'b00;
    tick();

    // Client 1 reads: rd_valid ahead of action_done, then coincident
    load(1, 1'b0, 25'h3, rnd(), BW'($urandom));
    c_req = 2'b10;
    serve(1, 0, 256'h1234, 1'b0, own);
    c_req = 2'b00;
    tick();
    load(1, 1'b0, 25'h3, rnd(), BW'($urandom));
    c_req = 2'b10;
    serve(2, 2, 256'h1234, 1'b0, own);
    c_req = 2'b00;
    tick();

    // Both requesting continuously: grants alternate starting with client 0
    load_rand(0); load_rand(1);
    c_req = 2'b11;
    for (int t = 0; t < 6; t++) begin
      dd = $urandom_range(0, 4);
      serve(dd, $urandom_range(0, dd), rnd(), 1'($urandom_range(0, 1)), own);
      chk("alt_order", own, t % 2);
      load_rand(own);
    end
    c_req = 2'b00;
    tick();

    // Randomized traffic, some back-to-back, some with cal_ok dipping mid-flight
    for (int t = 0; t < 25; t++) begin
      c_req = 2'($urandom_range(1, 3));
      dd = $urandom_range(0, 6);
      rv = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, dd);
      serve(dd, rv, rnd(), 1'($urandom_range(0, 1)), own);
      load_rand(own);
      if ($urandom_range(0, 1) == 1) begin
        c_req = 2'b00;
        tick();
        chk("idle_grant", grant, 2'b00);
      end
    end
    c_req = 2'b00;
    tick();

    // action_done never arrives
    load_rand(0);
    c_req = 2'b01;
    own = model_pick(c_req);
    tick();
    chk("to_grant", grant, 2'b01);
    tick();  // first WAIT cycle
`ifdef DDR_ARB_TIMEOUT_EN
    for (int k = 0; k < int'(TO); k++) begin
      tick();
      if (k < int'(TO) - 1) begin
        chk("to_pending_err", c_err, 2'b00);
        chk("to_pending_grant", grant, 2'b01);
      end else begin
        chk("to_err", c_err, 2'b01);
        chk("to_noack", c_ack, 2'b00);
        chk("to_flag", timeout_flag, 1'b1);
        chk("to_grant_clr", grant, 2'b00);
      end
    end
    last_srv = own;
    c_req = 2'b11;
    load_rand(0); load_rand(1);
    serve(0, -1, '0, 1'b0, own);
    chk("to_next_owner", own, 1);
    chk("to_flag_sticky", timeout_flag, 1'b1);
    c_req = 2'b01;
    own = model_pick(c_req);
    tick();
    tick();
    for (int k = 0; k < int'(TO); k++) begin
      action_done = (k == int'(TO) - 1);
      tick();
      action_done = 1'b0;
    end
    chk("to_tie_ack", c_ack, 2'b01);
    chk("to_tie_err", c_err, 2'b00);
    last_srv = own;
`else
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("hold_err", c_err, 2'b00);
      chk("hold_flag", timeout_flag, 1'b0);
      chk("hold_grant", grant, 2'b01);
    end
    action_done = 1'b1;
    tick();
    action_done = 1'b0;
    chk("hold_ack", c_ack, 2'b01);
    last_srv = own;
`endif
    c_req = 2'b00;
    tick();

    // Reset while WAITing: everything clears, a stale action_done is ignored
    load_rand(1);
    c_req = 2'b10;
    tick();
    tick();
    oh = grant;
    chk("pre_rst_grant", oh, 2'b10);
    #2 avalon_reset = 1'b1;
    #1;
    chk("arst_grant", grant, 2'b00);
    chk("arst_rq", {wr_rq, rd_rq}, 2'b00);
    chk("arst_adr", {wr_adr, rd_adr}, '0);
    chk("arst_wdata", wr_data, '0);
    chk("arst_be", byte_enable, '0);
    chk("arst_pulses", {c_ack, c_err, c_rvalid}, '0);
    chk("arst_rdata", c_rdata, '0);
    chk("arst_flag", timeout_flag, 1'b0);
    c_req = 2'b00;
    @(negedge avalon_clk) avalon_reset = 1'b0;
    last_srv = 1;
    action_done = 1'b1;
    tick();
    action_done = 1'b0;
    chk("late_done_noack", c_ack, 2'b00);
    tick();
    chk("late_done_noack2", c_ack, 2'b00);
    load_rand(0); load_rand(1);
    c_req = 2'b11;
    serve(1, -1, '0, 1'b0, own);
    chk("post_rst_owner", own, 0);
    c_req = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
